// File: rtl/wb_intercon_pkg.sv
// Shared types and constants for the registered Wishbone interconnect.
package wb_intercon_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2,
    StErr  = 2'd3
  } state_e;

  localparam logic [31:0] ErrDataDefault = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational base/mask address decoder; lowest matching slave index wins.
module wb_addr_decode
  import wb_intercon_pkg::*;
#(
  parameter int unsigned      AW        = 32,
  parameter int unsigned      NS        = 6,
  parameter logic [NS*AW-1:0] SLAVE_ADR = '0,
  parameter logic [NS*AW-1:0] ADR_MASK  = '0
) (
  input  logic [AW-1:0] adr,
  output logic [NS-1:0] match,
  output logic          hit
);

  always_comb begin
    match = '0;
    hit   = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (!hit && ((adr & ADR_MASK[i*AW +: AW]) ==
                   (SLAVE_ADR[i*AW +: AW] & ADR_MASK[i*AW +: AW]))) begin
        match[i] = 1'b1;
        hit      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_intercon_reg.sv
// Registered single-master Wishbone classic interconnect to NS slaves.
// Optional slave timeout: define WB_ICON_TIMEOUT_EN.
module wb_intercon_reg
  import wb_intercon_pkg::*;
#(
  parameter int unsigned      AW        = 32,
  parameter int unsigned      DW        = 32,
  parameter int unsigned      NS        = 6,
  parameter logic [NS*AW-1:0] SLAVE_ADR = {32'h2800_0000, 32'h2300_0000, 32'h2100_0000,
                                           32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NS*AW-1:0] ADR_MASK  = {NS{32'hFF00_0000}},
  parameter int unsigned      TO_CYCLES = 255,
  parameter logic [DW-1:0]    ERR_DATA  = DW'(ErrDataDefault)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbm_cyc_i,
  input  logic             wbm_stb_i,
  input  logic             wbm_we_i,
  input  logic [DW/8-1:0]  wbm_sel_i,
  input  logic [AW-1:0]    wbm_adr_i,
  input  logic [DW-1:0]    wbm_dat_i,
  output logic [DW-1:0]    wbm_dat_o,
  output logic             wbm_ack_o,
  output logic             wbm_err_o,
  output logic [NS-1:0]    wbs_cyc_o,
  output logic [NS-1:0]    wbs_stb_o,
  output logic             wbs_we_o,
  output logic [DW/8-1:0]  wbs_sel_o,
  output logic [AW-1:0]    wbs_adr_o,
  output logic [DW-1:0]    wbs_dat_o,
  input  logic [NS*DW-1:0] wbs_dat_i,
  input  logic [NS-1:0]    wbs_ack_i
);

  state_e          state_q;
  logic [NS-1:0]   sel_q;
  logic            we_q;
  logic [DW/8-1:0] byte_sel_q;
  logic [AW-1:0]   adr_q;
  logic [DW-1:0]   wdat_q;
  logic [DW-1:0]   rdat_q;
  logic            ack_q;
  logic            err_q;

  logic [NS-1:0]   match;
  logic            hit;
  logic            slv_ack;
  logic [DW-1:0]   slv_dat;

`ifdef WB_ICON_TIMEOUT_EN
  localparam int unsigned ToW    = $clog2(TO_CYCLES + 1);
  // Expiry is flagged on the cycle whose increment would reach TO_CYCLES.
  localparam logic [ToW-1:0] ToLast = ToW'(TO_CYCLES - 1);
  logic [ToW-1:0] to_cnt_q;
`endif

  wb_addr_decode #(
    .AW        (AW),
    .NS        (NS),
    .SLAVE_ADR (SLAVE_ADR),
    .ADR_MASK  (ADR_MASK)
  ) u_decode (
    .adr   (wbm_adr_i),
    .match (match),
    .hit   (hit)
  );

  // Only the selected slave's ack and data are visible to the FSM.
  assign slv_ack = |(wbs_ack_i & sel_q);

  always_comb begin
    slv_dat = '0;
    for (int i = 0; i < NS; i++) begin
      if (sel_q[i]) slv_dat = wbs_dat_i[i*DW +: DW];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      we_q       <= 1'b0;
      byte_sel_q <= '0;
      adr_q      <= '0;
      wdat_q     <= '0;
      rdat_q     <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
`ifdef WB_ICON_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      rdat_q <= '0;
      case (state_q)
        StIdle: begin
          if (wbm_cyc_i && wbm_stb_i) begin
            we_q       <= wbm_we_i;
            byte_sel_q <= wbm_sel_i;
            adr_q      <= wbm_adr_i;
            wdat_q     <= wbm_dat_i;
            if (hit) begin
              sel_q   <= match;
              state_q <= StWait;
`ifdef WB_ICON_TIMEOUT_EN
              to_cnt_q <= '0;
`endif
            end else begin
              err_q   <= 1'b1;
              rdat_q  <= ERR_DATA;
              state_q <= StErr;
            end
          end
        end
        StWait: begin
          if (!wbm_cyc_i) begin
            sel_q   <= '0;
            state_q <= StIdle;
          end else if (slv_ack) begin
            sel_q   <= '0;
            ack_q   <= 1'b1;
            rdat_q  <= we_q ? '0 : slv_dat;
            state_q <= StResp;
`ifdef WB_ICON_TIMEOUT_EN
          end else if (to_cnt_q == ToLast) begin
            sel_q   <= '0;
            err_q   <= 1'b1;
            rdat_q  <= ERR_DATA;
            state_q <= StErr;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
`endif
          end
        end
        // Response cycles always return to idle, so a held stb is not re-accepted.
        StResp:  state_q <= StIdle;
        StErr:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wbm_dat_o = rdat_q;
  assign wbm_ack_o = ack_q;
  assign wbm_err_o = err_q;
  assign wbs_cyc_o = sel_q;
  assign wbs_stb_o = sel_q;
  assign wbs_we_o  = we_q;
  assign wbs_sel_o = byte_sel_q;
  assign wbs_adr_o = adr_q;
  assign wbs_dat_o = wdat_q;

endmodule

// File: tb/tb_wb_intercon_reg.sv
// Self-checking bench for wb_intercon_reg: directed and randomized accesses vs. a memory model.
module tb_wb_intercon_reg;

  localparam int unsigned NS = 6;
`ifdef WB_ICON_TIMEOUT_EN
  localparam int unsigned ToCycles = 8;
`else
  localparam int unsigned ToCycles = 255;
`endif
  localparam logic [31:0] ErrWord = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
  logic [3:0]    m_sel = '0;
  logic [31:0]   m_adr = '0, m_wdat = '0;
  logic [31:0]   m_rdat;
  logic          m_ack, m_err;
  logic [NS-1:0] s_cyc, s_stb;
  logic          s_we;
  logic [3:0]    s_sel;
  logic [31:0]   s_adr, s_wdat;
  logic [NS*32-1:0] s_rdat;
  logic [NS-1:0] s_ack;

  // Dummy slaves: one word each, registered 1-cycle ack unless silenced.
  logic [NS-1:0] sl_ack;
  logic [NS-1:0] silent = '0;
  logic [NS-1:0] force_ack = '0;
  logic [31:0]   sl_mem [NS] = '{default: 32'h0};

  logic [31:0] bases [NS] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000,
                              32'h2100_0000, 32'h2300_0000, 32'h2800_0000};
  logic [31:0] model_mem [NS] = '{default: 32'h0};

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  wb_intercon_reg #(
    .TO_CYCLES (ToCycles)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbm_cyc_i (m_cyc),
    .wbm_stb_i (m_stb),
    .wbm_we_i  (m_we),
    .wbm_sel_i (m_sel),
    .wbm_adr_i (m_adr),
    .wbm_dat_i (m_wdat),
    .wbm_dat_o (m_rdat),
    .wbm_ack_o (m_ack),
    .wbm_err_o (m_err),
    .wbs_cyc_o (s_cyc),
    .wbs_stb_o (s_stb),
    .wbs_we_o  (s_we),
    .wbs_sel_o (s_sel),
    .wbs_adr_o (s_adr),
    .wbs_dat_o (s_wdat),
    .wbs_dat_i (s_rdat),
    .wbs_ack_i (s_ack)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sl_ack <= '0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        sl_ack[i] <= s_cyc[i] & s_stb[i] & ~sl_ack[i] & ~silent[i];
        if (s_cyc[i] & s_stb[i] & s_we & ~sl_ack[i] & ~silent[i]) sl_mem[i] <= s_wdat;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NS; i++) s_rdat[i*32 +: 32] = sl_mem[i];
  end
  assign s_ack = sl_ack | force_ack;

  wire [127:0] all_outs = {13'b0, m_rdat, m_ack, m_err, s_cyc, s_stb, s_we, s_sel, s_adr, s_wdat};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference decode: first window whose top byte equals the address top byte.
  function automatic int target(input logic [31:0] adr);
    for (int i = 0; i < NS; i++) if (adr[31:24] == bases[i][31:24]) return i;
    return -1;
  endfunction

  // res: 0 = no response within bound, 1 = ack, 2 = err.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                      input logic [3:0] sel, input int ack_at,
                      output int res, output logic [31:0] rdat, output int lat,
                      output logic [NS-1:0] stb_or, output logic multi,
                      output logic [68:0] seen, output logic tail);
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_adr = adr; m_wdat = wdat; m_sel = sel;
    res = 0; lat = 0; stb_or = '0; multi = 1'b0; seen = '0; rdat = '0;
    while (res == 0 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      force_ack = '0;
      stb_or |= s_stb;
      if ($countones(s_stb) > 1) multi = 1'b1;
      if (lat == 1) seen = {s_we, s_sel, s_adr, s_wdat};
      if (m_ack) begin
        res = 1; rdat = m_rdat;
      end else if (m_err) begin
        res = 2; rdat = m_rdat;
      end else if (lat == ack_at) begin
        force_ack = s_stb;
      end
    end
    m_cyc = 1'b0; m_stb = 1'b0;
    @(posedge clk); #1;
    tail = m_ack | m_err;
  endtask

  int            res, lat, exp_idx;
  logic [31:0]   rdat, adr, wdat;
  logic [NS-1:0] stb_or;
  logic          multi, tail, we, resp_seen;
  logic [68:0]   seen;
  logic [3:0]    sel;
  logic [7:0]    tops [10] = '{8'h00, 8'h10, 8'h20, 8'h21, 8'h23, 8'h28,
                               8'h30, 8'hFF, 8'h05, 8'h22};

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 check("reset_outputs", all_outs, '0);
    @(negedge clk) rst = 1'b0;

    // Write then read 0x2100_0000
    xfer(1'b1, 32'h2100_0000, 32'h1234_5678, 4'hF, 0, res, rdat, lat, stb_or, multi, seen, tail);
    check("t1_wr_resp", res, 1);
    check("t1_wr_stb", stb_or, 6'b001000);
    check("t1_wr_dat0", rdat, 0);
    check("t1_wr_bcast", seen, {1'b1, 4'hF, 32'h2100_0000, 32'h1234_5678});
    model_mem[3] = 32'h1234_5678;
    xfer(1'b0, 32'h2100_0000, 32'h0, 4'h5, 0, res, rdat, lat, stb_or, multi, seen, tail);
    check("t1_rd_resp", res, 1);
    check("t1_rd_data", rdat, 32'h1234_5678);
    check("t1_rd_latency", lat, 3);
    check("t1_rd_sel", seen[67:64], 4'h5);
    check("t1_ack_pulse", tail, 1'b0);

    // Unmapped read
    xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, res, rdat, lat, stb_or, multi, seen, tail);
    check("t2_err_resp", res, 2);
    check("t2_err_data", rdat, ErrWord);
    check("t2_err_latency", lat, 1);
    check("t2_no_stb", stb_or, '0);
    check("t2_err_pulse", tail, 1'b0);

    // Every window: random write then readback
    for (int i = 0; i < NS; i++) begin
      adr = bases[i] | ($urandom & 32'h00FF_FFFC);
      wdat = $urandom;
      xfer(1'b1, adr, wdat, 4'hF, 0, res, rdat, lat, stb_or, multi, seen, tail);
      model_mem[i] = wdat;
      check("t3_wr_resp", res, 1);
      check("t3_wr_stb", {multi, stb_or}, {1'b0, 6'(1 << i)});
    end
    for (int i = 0; i < NS; i++) begin
      xfer(1'b0, bases[i] | 32'h40, 32'h0, 4'hF, 0, res, rdat, lat, stb_or, multi, seen, tail);
      check("t3_rd_data", {res[1:0], rdat}, {2'd1, model_mem[i]});
      check("t3_rd_stb", {multi, stb_or}, {1'b0, 6'(1 << i)});
    end

    // Random mix of mapped/unmapped reads and writes
    for (int n = 0; n < 24; n++) begin
      adr = {tops[$urandom_range(0, 9)], 24'($urandom)};
      wdat = $urandom;
      we = 1'($urandom);
      sel = 4'($urandom);
      exp_idx = target(adr);
      xfer(we, adr, wdat, sel, 0, res, rdat, lat, stb_or, multi, seen, tail);
      if (exp_idx < 0) begin
        check("rnd_unmapped", {res[1:0], rdat, stb_or}, {2'd2, ErrWord, 6'b0});
      end else begin
        check("rnd_mapped", {res[1:0], rdat, stb_or, multi},
              {2'd1, (we ? 32'h0 : model_mem[exp_idx]), 6'(1 << exp_idx), 1'b0});
        check("rnd_bcast", seen, {we, sel, adr, wdat});
        if (we) model_mem[exp_idx] = wdat;
      end
    end

    // Master abort on a silent slave, then a late stray ack
    silent[1] = 1'b1;
    resp_seen = 1'b0;
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h1000_0000; m_sel = 4'hF;
    repeat (3) begin
      @(posedge clk); #1 resp_seen |= m_ack | m_err;
    end
    check("t4_wait_stb", s_stb, 6'b000010);
    @(negedge clk);
    m_cyc = 1'b0; m_stb = 1'b0;
    @(posedge clk); #1 resp_seen |= m_ack | m_err;
    check("t4_abort_clear", {s_cyc, s_stb}, '0);
    force_ack = 6'b000010;
    @(posedge clk); #1 resp_seen |= m_ack | m_err;
    force_ack = '0;
    repeat (2) begin
      @(posedge clk); #1 resp_seen |= m_ack | m_err;
    end
    check("t4_no_resp", resp_seen, 1'b0);
    silent[1] = 1'b0;
    xfer(1'b0, 32'h1000_0000, 32'h0, 4'hF, 0, res, rdat, lat, stb_or, multi, seen, tail);
    check("t4_next_ok", {res[1:0], rdat}, {2'd1, model_mem[1]});

`ifdef WB_ICON_TIMEOUT_EN
    // Timeout on a silent slave, and an ack on the expiry cycle
    silent[0] = 1'b1;
    xfer(1'b0, 32'h0000_0100, 32'h0, 4'hF, 0, res, rdat, lat, stb_or, multi, seen, tail);
    check("t5_timeout", {res[1:0], rdat, 8'(lat)}, {2'd2, ErrWord, 8'd9});
    xfer(1'b0, 32'h0000_0100, 32'h0, 4'hF, 8, res, rdat, lat, stb_or, multi, seen, tail);
    check("t5_ack_wins", {res[1:0], rdat, 8'(lat)}, {2'd1, model_mem[0], 8'd9});
    silent[0] = 1'b0;
`endif

    // Reset during WAIT
    silent[4] = 1'b1;
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h2300_0000; m_sel = 4'hF;
    repeat (2) @(posedge clk);
    #1 check("t6_wait_stb", s_stb, 6'b010000);
    @(negedge clk) rst = 1'b1;
    #1 check("t6_async_reset", all_outs, '0);
    m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk) rst = 1'b0;
    silent[4] = 1'b0;
    xfer(1'b0, 32'h2300_0000, 32'h0, 4'hF, 0, res, rdat, lat, stb_or, multi, seen, tail);
    check("t6_after_reset", {res[1:0], rdat, 8'(lat)}, {2'd1, model_mem[4], 8'd3});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
